// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths and
// the clear-engine state encoding.
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_mp_bypass.sv
// Per-read-port output select: forces zero while the clear sweep runs or for
// the hardwired zero entry, forwards same-cycle write data, else array data.
module rf_bypass_mux
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              busy,
  input  logic [ADDR_W-1:0] ra,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] rd
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  // Priority chain: busy, zero entry, port-1 forward, port-0 forward, array.
  always_comb begin
    rd = arr_data;
    if (busy) begin
      rd = '0;
    end else if (ZR && (ra == '0)) begin
      rd = '0;
    end else if (BP && we1 && (wa1 == ra)) begin
      rd = wd1;
    end else if (BP && we0 && (wa0 == ra)) begin
      rd = wd0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with optional write-to-read bypass,
// port-1-wins write priority, a registered debug read port and a sequential
// clear engine. The array itself has no reset so it can map to distributed
// RAM; the sweep after reset (or on clr_req) zeroes it one entry per cycle.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok0;
  logic              wr_ok1;

  // Writes to the hardwired zero entry are discarded without flagging a drop.
  assign wr_ok0 = we0 && !(ZR && (wa0 == '0));
  assign wr_ok1 = we1 && !(ZR && (wa1 == '0));

  // Clear-engine state register; reset always starts a fresh sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CLEAR;
    else      state <= state_next;
  end

  // Sweep ends on the edge that clears the last entry; IDLE waits for clr_req.
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (ptr == LAST_PTR) state_next = ST_IDLE;
      ST_IDLE:  if (clr_req)         state_next = ST_CLEAR;
      default:                       state_next = ST_CLEAR;
    endcase
  end

  // Busy is simply "sweep in progress".
  always_comb begin
    busy = (state == ST_CLEAR);
  end

  // Sweep pointer advances only while clearing and is parked at 0 in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   ptr <= '0;
    else if (state == ST_CLEAR) ptr <= ptr + 1'b1;
    else                        ptr <= '0;
  end

  // Array update: the sweep owns the array while busy; otherwise port 1 is
  // written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else begin
      if (wr_ok0) mem[wa0] <= wd0;
      if (wr_ok1) mem[wa1] <= wd1;
    end
  end

  // Flag any write attempted while the sweep had the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_drop <= 1'b0;
    else      wr_drop <= busy && (we0 || we1);
  end

  // Debug port shows raw array contents, including mid-sweep, with no bypass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        dbg_data <= '0;
    else if (ZR && (dbg_addr == '0)) dbg_data <= '0;
    else                             dbg_data <= mem[dbg_addr];
  end

  rf_bypass_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd0_mux (
    .busy    (busy),
    .ra      (ra0),
    .we0     (we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .arr_data(mem[ra0]),
    .rd      (rd0)
  );

  rf_bypass_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd1_mux (
    .busy    (busy),
    .ra      (ra1),
    .we0     (we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .arr_data(mem[ra1]),
    .rd      (rd1)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic,
// all compared against a behavioural model of the register file.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_req = 1'b0;
  logic          busy;
  logic [AW-1:0] ra0 = '0, ra1 = '0;
  logic [DW-1:0] rd0, rd1;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic          wr_drop;

  int checks = 0;
  int failures = 0;

  // Behavioural model: contents, which entries hold a known value, and the
  // number of sweep cycles still to run (nonzero means busy).
  logic [DW-1:0] mem_m [DEPTH];
  bit            known_m [DEPTH];
  int            clr_left;
  logic [DW-1:0] dbg_m;
  bit            dbg_known;
  bit            drop_m;

  // Last values observed mid-cycle, for directed checks.
  logic          last_busy;
  logic [DW-1:0] last_rd0, last_rd1;
  logic          last_drop;

  reg_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] ra, output bit valid);
    valid = 1'b1;
    if (clr_left > 0) return '0;
    if (ra == 0) return '0;
    if (we1 && wa1 == ra) return wd1;
    if (we0 && wa0 == ra) return wd0;
    valid = known_m[ra];
    return mem_m[ra];
  endfunction

  task automatic model_reset();
    clr_left  = DEPTH;
    drop_m    = 1'b0;
    dbg_m     = '0;
    dbg_known = 1'b1;
  endtask

  task automatic model_edge();
    dbg_known = (dbg_addr == 0) || known_m[dbg_addr];
    dbg_m     = (dbg_addr == 0) ? '0 : mem_m[dbg_addr];
    drop_m    = (clr_left > 0) && (we0 || we1);
    if (clr_left > 0) begin
      mem_m[DEPTH - clr_left]   = '0;
      known_m[DEPTH - clr_left] = 1'b1;
      clr_left--;
    end else begin
      if (we0 && wa0 != 0) begin mem_m[wa0] = wd0; known_m[wa0] = 1'b1; end
      if (we1 && wa1 != 0) begin mem_m[wa1] = wd1; known_m[wa1] = 1'b1; end
      if (clr_req) clr_left = DEPTH;
    end
  endtask

  task automatic check_cycle();
    bit            v;
    logic [DW-1:0] e;
    last_busy = busy;
    last_rd0  = rd0;
    last_rd1  = rd1;
    last_drop = wr_drop;
    check_output("busy", {31'b0, busy}, {31'b0, clr_left > 0});
    e = exp_read(ra0, v);
    if (v) check_output("rd0", rd0, e);
    e = exp_read(ra1, v);
    if (v) check_output("rd1", rd1, e);
    if (dbg_known) check_output("dbg_data", dbg_data, dbg_m);
    check_output("wr_drop", {31'b0, wr_drop}, {31'b0, drop_m});
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_stimulus(input bit c, input bit e0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input bit e1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d1, input logic [AW-1:0] r0,
                                input logic [AW-1:0] r1, input logic [AW-1:0] da);
    clr_req = c; we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    ra0 = r0; ra1 = r1; dbg_addr = da;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Runs until the sweep finishes, counting busy cycles after the last reset.
  task automatic run_sweep(input string tag, input int write_at, input int reset_at);
    int n = 0;
    bit seen_idle = 1'b0;
    for (int i = 0; i < 120 && !seen_idle; i++) begin
      if (i == reset_at) begin
        do_reset();
        n = 0;
      end
      clr_req  = (clr_left > 0) && (i % 5 == 1);
      we0      = (i == write_at);
      wa0      = 5'd9;
      wd0      = $urandom;
      we1      = 1'b0;
      ra0      = 5'($urandom);
      ra1      = 5'($urandom);
      dbg_addr = 5'($urandom);
      step();
      if (last_busy) n++;
      else seen_idle = 1'b1;
    end
    check_output({tag, "_busy_len"}, n, DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = 1'b0;
    end
    model_reset();
    #1;
    do_reset();

    // Power-up sweep and full debug readback.
    run_sweep("init", -1, -1);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i));
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle bypass, then the committed value.
    apply_stimulus(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0, 3);
    check_output("t2_bypass", last_rd0, 32'hDEADBEEF);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 3, 3, 3);
    check_output("t2_after", last_rd0, 32'hDEADBEEF);

    // Write collision: port 1 wins.
    apply_stimulus(0, 1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 7, 7);
    check_output("t3_bypass", last_rd0, 32'h22222222);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 7, 7, 7);
    check_output("t3_array", last_rd0, 32'h22222222);

    // Zero register ignores writes without flagging a drop.
    apply_stimulus(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    check_output("t4_rd1", last_rd1, 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("t4_rd1_next", last_rd1, 32'h0);
    check_output("t4_drop", {31'b0, last_drop}, 32'h0);

    // Clear request with a same-cycle write, plus a dropped write mid-sweep.
    apply_stimulus(1, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 5, 5, 5);
    check_output("t5_bypass", last_rd0, 32'hA5A5A5A5);
    run_sweep("t5", 3, -1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 9, 5);
    check_output("t5_entry5", last_rd0, 32'h0);

    // Reset in the middle of a sweep restarts it from the beginning.
    apply_stimulus(0, 1, 12, 32'h12345678, 0, 0, 0, 12, 0, 12);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 12, 0, 12);
    run_sweep("t6", -1, 16);

    // Random traffic; half of the addresses are squeezed into a small range
    // so collisions and bypass hits happen often.
    for (int i = 0; i < 600; i++) begin
      bit narrow = $urandom_range(0, 1) == 1;
      clr_req  = ($urandom_range(0, 59) == 0);
      we0      = $urandom_range(0, 1) == 1;
      we1      = $urandom_range(0, 1) == 1;
      wa0      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa1      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd0      = $urandom;
      wd1      = $urandom;
      ra0      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra1      = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      dbg_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
